// File: rtl/tube_pkg.sv
// Shared constants, payload types and segment patterns for the tube_ctrl display slice.
package tube_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NDIG   = 8;

  localparam logic [ADDR_W-1:0] TUBE_DATA_ADDR = 14'h3C80;
  localparam logic [ADDR_W-1:0] TUBE_CTRL_ADDR = 14'h3C84;

  localparam int unsigned CTRL_DEC_BIT   = 0;
  localparam int unsigned CTRL_BLANK_BIT = 1;
  localparam int unsigned CTRL_MASK_LSB  = 8;

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low glyphs, index = hex code (F first so entry [0] is "0").
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef logic [NDIG-1:0][3:0] digits_t;

  typedef struct packed {
    digits_t         code;
    logic [NDIG-1:0] dash;
  } disp_t;

  function automatic logic [7:0] seg_pattern(input logic [3:0] code, input logic dash);
    return dash ? SEG_DASH : SEG_HEX[code];
  endfunction

endpackage

// File: rtl/tube_bin2bcd.sv
// Sequential double-dabble: 32 shift iterations plus one finish cycle.
// Only built when TUBE_BCD_EN is defined.
`ifdef TUBE_BCD_EN
module tube_bin2bcd
  import tube_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] bin_i,
  output logic              busy_o,
  output logic              done_o,
  output digits_t           bcd_o,
  output logic              ovf_o
);

  localparam int unsigned       CNT_W   = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] BCD_MAX = DATA_W'(99_999_999);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [DATA_W-1:0] bcd_q, bcd_d;
  logic [DATA_W-1:0] adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Add-3 correction on every BCD nibble before the shift.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // A start always wins, so a write during a conversion restarts it.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_SHIFT: begin
        bcd_d = DATA_W'({adj, bin_q[DATA_W-1]});
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W-1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: ;
    endcase
    if (start_i) begin
      state_d = S_SHIFT;
      bin_d   = bin_i;
      bcd_d   = '0;
      cnt_d   = '0;
      ovf_d   = (bin_i > BCD_MAX);
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = digits_t'(bcd_q);
  assign ovf_o  = ovf_q;

endmodule
`endif

// File: rtl/tube_ctrl.sv
// Memory-mapped 8-digit seven-segment controller with scan multiplexing.
// Define TUBE_BCD_EN to build decimal mode and the bin2bcd converter.
module tube_ctrl
  import tube_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [7:0]        seg_o,
  output logic [NDIG-1:0]   an_o,
  output logic              busy_o
);

  localparam int unsigned PRE_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = $clog2(NDIG);

  logic              wr_data, wr_ctrl, dec_mode, lit;
  logic              blank_q, blank_d;
  logic [NDIG-1:0]   mask_q, mask_d;
  disp_t             disp_q, disp_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        seg_q, seg_d;
  logic [NDIG-1:0]   an_q, an_d;

  assign wr_data = io_write_i && (addr_i == TUBE_DATA_ADDR);
  assign wr_ctrl = io_write_i && (addr_i == TUBE_CTRL_ADDR);

`ifdef TUBE_BCD_EN
  logic    dec_q, dec_d, conv_start, conv_done, conv_ovf, conv_busy;
  digits_t conv_bcd;

  assign dec_mode   = dec_q;
  assign conv_start = wr_data && dec_q;
  assign dec_d      = wr_ctrl ? wdata_i[CTRL_DEC_BIT] : dec_q;

  always_ff @(posedge clk) begin
    if (rst) dec_q <= 1'b0;
    else     dec_q <= dec_d;
  end

  tube_bin2bcd u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (conv_start),
    .bin_i   (wdata_i),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd),
    .ovf_o   (conv_ovf)
  );

  assign busy_o = conv_busy;
`else
  assign dec_mode = 1'b0;
  assign busy_o   = 1'b0;
`endif

  always_comb begin
    blank_d = blank_q;
    mask_d  = mask_q;
    if (wr_ctrl) begin
      blank_d = wdata_i[CTRL_BLANK_BIT];
      mask_d  = wdata_i[CTRL_MASK_LSB +: NDIG];
    end
  end

  // Finished conversion lands atomically unless a new DATA write supersedes it.
  always_comb begin
    disp_d = disp_q;
`ifdef TUBE_BCD_EN
    if (conv_done && !conv_start) begin
      disp_d.code = conv_bcd;
      disp_d.dash = {NDIG{conv_ovf}};
    end
`endif
    if (wr_data && !dec_mode) begin
      disp_d.code = digits_t'(wdata_i);
      disp_d.dash = '0;
    end
  end

  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (pre_q == PRE_W'(SCAN_DIV-1)) begin
      pre_d = '0;
      idx_d = idx_q + IDX_W'(1);
    end
    lit  = mask_q[idx_q] && !blank_q;
    an_d = '1;
    seg_d = SEG_BLANK;
    if (lit) begin
      an_d  = ~(NDIG'(1) << idx_q);
      seg_d = seg_pattern(disp_q.code[idx_q], disp_q.dash[idx_q]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blank_q <= 1'b0;
      mask_q  <= '1;
      disp_q  <= '0;
      pre_q   <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_HEX[0];
      an_q    <= ~NDIG'(1);
    end else begin
      blank_q <= blank_d;
      mask_q  <= mask_d;
      disp_q  <= disp_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg_o = seg_q;
  assign an_o  = an_q;

endmodule

// File: tb/tb_tube_ctrl.sv
// Directed self-checking bench for tube_ctrl with a short scan period.
module tb_tube_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_write;
  logic [13:0] addr;
  logic [31:0] wdata;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tube_ctrl #(.SCAN_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .io_write_i (io_write),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .seg_o      (seg),
    .an_o       (an),
    .busy_o     (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    io_write = 1'b1;
    addr     = a;
    wdata    = d;
    tick();
    io_write = 1'b0;
    addr     = 14'h0;
    wdata    = 32'h0;
  endtask

  task automatic wait_an(input logic [7:0] want, output bit found);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (an === want) found = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; io_write = 1'b0; addr = 14'h0; wdata = 32'h0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++;
    if (an !== 8'hFE) begin errors++; $display("FAIL reset_an got=%h want=fe", an); end
    checks++;
    if (seg !== 8'hC0) begin errors++; $display("FAIL reset_seg got=%h want=c0", seg); end
    rst = 1'b0;
  endtask

  task automatic test_hex_scan();
    logic [7:0] exp [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [7:0] want;
    bit found;
    int n;
    wr(14'h3C80, 32'h12345678);
    tick(); tick();
    for (int d = 0; d < 8; d++) begin
      want = ~(8'h01 << d);
      wait_an(want, found);
      checks++;
      if (!found || seg !== exp[d]) begin
        errors++; $display("FAIL hex_digit%0d an=%h seg=%h want an=%h seg=%h", d, an, seg, want, exp[d]);
      end
    end
    n = 0;
    while (an === 8'hFE && n < 100) begin tick(); n++; end
    while (an !== 8'hFE && n < 100) begin tick(); n++; end
    n = 0;
    while (an === 8'hFE && n < 100) begin tick(); n++; end
    while (an !== 8'hFE && n < 100) begin tick(); n++; end
    checks++;
    if (n != 32) begin errors++; $display("FAIL scan_period got=%0d want=32", n); end
  endtask

  task automatic test_ctrl_mask();
    int dark, bad;
    logic [3:0] seen;
    wr(14'h3C84, 32'h0000_0F00);
    tick(); tick();
    dark = 0; bad = 0; seen = 4'h0;
    for (int i = 0; i < 32; i++) begin
      if (an === 8'hFF) begin
        dark++;
        if (seg !== 8'hFF) bad++;
      end else begin
        case (an)
          8'hFE: seen[0] = 1'b1;
          8'hFD: seen[1] = 1'b1;
          8'hFB: seen[2] = 1'b1;
          8'hF7: seen[3] = 1'b1;
          default: bad++;
        endcase
        if (seg === 8'hFF) bad++;
      end
      tick();
    end
    checks++;
    if (dark != 16) begin errors++; $display("FAIL mask_dark_cycles got=%0d want=16", dark); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mask_pairing bad=%0d want=0", bad); end
    checks++;
    if (seen !== 4'hF) begin errors++; $display("FAIL mask_lit_digits got=%h want=f", seen); end
    wr(14'h3C84, 32'h0000_0002);
    tick(); tick();
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (an !== 8'hFF || seg !== 8'hFF) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL blank_all lit_cycles=%0d want=0", bad); end
    wr(14'h3C84, 32'h0000_FF00);
  endtask

`ifdef TUBE_BCD_EN
  task automatic test_decimal();
    logic [7:0] exp [8] = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    logic [7:0] want;
    bit found;
    int n;
    wr(14'h3C84, 32'h0000_FF01);
    wr(14'h3C80, 32'd1234);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL dec_busy_rise got=%b want=1", busy); end
    n = 0;
    while (busy === 1'b1 && n < 100) begin n++; tick(); end
    checks++;
    if (n != 33) begin errors++; $display("FAIL dec_busy_len got=%0d want=33", n); end
    tick();
    for (int d = 0; d < 8; d++) begin
      want = ~(8'h01 << d);
      wait_an(want, found);
      checks++;
      if (!found || seg !== exp[d]) begin
        errors++; $display("FAIL dec_digit%0d an=%h seg=%h want an=%h seg=%h", d, an, seg, want, exp[d]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] want;
    bit found;
    int n;
    wr(14'h3C80, 32'd100_000_000);
    n = 0;
    while (busy === 1'b1 && n < 100) begin n++; tick(); end
    checks++;
    if (n != 33) begin errors++; $display("FAIL ovf_busy_len got=%0d want=33", n); end
    tick();
    for (int d = 0; d < 8; d++) begin
      want = ~(8'h01 << d);
      wait_an(want, found);
      checks++;
      if (!found || seg !== 8'hBF) begin
        errors++; $display("FAIL ovf_digit%0d an=%h seg=%h want seg=bf", d, an, seg);
      end
    end
  endtask

  task automatic test_restart();
    bit found;
    bit seen5;
    int n;
    seen5 = 1'b0;
    wr(14'h3C80, 32'd5);
    for (int i = 0; i < 8; i++) begin
      if (seg === 8'h92) seen5 = 1'b1;
      tick();
    end
    wr(14'h3C80, 32'd7);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (seg === 8'h92) seen5 = 1'b1;
      n++; tick();
    end
    checks++;
    if (n != 33) begin errors++; $display("FAIL restart_busy_len got=%0d want=33", n); end
    for (int i = 0; i < 40; i++) begin
      if (seg === 8'h92) seen5 = 1'b1;
      tick();
    end
    checks++;
    if (seen5) begin errors++; $display("FAIL restart_stale_value got=shown want=never_shown"); end
    wait_an(8'hFE, found);
    checks++;
    if (!found || seg !== 8'hF8) begin errors++; $display("FAIL restart_digit0 seg=%h want=f8", seg); end
  endtask
`else
  task automatic test_dec_ignored();
    logic [7:0] exp [8] = '{8'hC6, 8'h83, 8'h88, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    logic [7:0] want;
    bit found;
    wr(14'h3C84, 32'h0000_FF01);
    wr(14'h3C80, 32'h0000_0ABC);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL nodec_busy got=%b want=0", busy); end
    tick(); tick();
    for (int d = 0; d < 8; d++) begin
      want = ~(8'h01 << d);
      wait_an(want, found);
      checks++;
      if (!found || seg !== exp[d]) begin
        errors++; $display("FAIL nodec_digit%0d an=%h seg=%h want an=%h seg=%h", d, an, seg, want, exp[d]);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    int bad;
    bit saw_last;
`ifdef TUBE_BCD_EN
    wr(14'h3C84, 32'h0000_FF01);
    wr(14'h3C80, 32'd99);
`else
    wr(14'h3C80, 32'h9999_9999);
`endif
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    checks++;
    if (an !== 8'hFE) begin errors++; $display("FAIL rstmid_an got=%h want=fe", an); end
    checks++;
    if (seg !== 8'hC0) begin errors++; $display("FAIL rstmid_seg got=%h want=c0", seg); end
    bad = 0; saw_last = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (seg !== 8'hC0 || busy !== 1'b0) bad++;
      if (an === 8'h7F) saw_last = 1'b1;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rstmid_zeros bad=%0d want=0", bad); end
    checks++;
    if (!saw_last) begin errors++; $display("FAIL rstmid_scan digit7 got=unseen want=seen"); end
  endtask

  initial begin
    test_reset();
    test_hex_scan();
    test_ctrl_mask();
`ifdef TUBE_BCD_EN
    test_decimal();
    test_overflow();
    test_restart();
`else
    test_dec_ignored();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
